// File: rtl/line_gfx_pkg.sv
// Shared types and screen constants for the line-drawing front end.
// Holds the queued command format, the issue FSM states and the clamp helpers.
package line_gfx_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef struct packed {
    logic       clear;
    logic [9:0] x0;
    logic [8:0] y0;
    logic [9:0] x1;
    logic [8:0] y1;
  } line_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } q_state_t;

  function automatic logic [9:0] clamp_x(input logic [9:0] x, input logic [9:0] max_x);
    return (x > max_x) ? max_x : x;
  endfunction

  function automatic logic [8:0] clamp_y(input logic [8:0] y, input logic [8:0] max_y);
    return (y > max_y) ? max_y : y;
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous FIFO of line_cmd_t entries; DEPTH must be a power of two >= 2.
// Pushes on full and pops on empty are ignored; full/empty come from the count.
module line_cmd_fifo
  import line_gfx_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  line_cmd_t wdata,
  input  logic      pop,
  output line_cmd_t rdata,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  line_cmd_t       mem [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push_en;
  logic            pop_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) wptr_d = wptr_q + 1'b1;
    if (pop_en)  rptr_d = rptr_q + 1'b1;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/line_cmd_queue.sv
// Command queue in front of the line drawer: clamps, buffers and issues one command at a time.
// Define LINE_CMD_QUEUE_TIMEOUT_EN to add the WAIT watchdog and the sticky timeout_err flag.
module line_cmd_queue
  import line_gfx_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned SCREEN_W       = line_gfx_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H       = line_gfx_pkg::SCREEN_H,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_clear,
  input  logic [9:0]             cmd_x0,
  input  logic [8:0]             cmd_y0,
  input  logic [9:0]             cmd_x1,
  input  logic [8:0]             cmd_y1,
  output logic [9:0]             draw_x0,
  output logic [8:0]             draw_y0,
  output logic [9:0]             draw_x1,
  output logic [8:0]             draw_y1,
  output logic                   draw_start,
  output logic                   draw_clean,
  input  logic                   draw_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   timeout_err
);

  localparam logic [9:0] MaxX = 10'(SCREEN_W - 1);
  localparam logic [8:0] MaxY = 9'(SCREEN_H - 1);

  line_cmd_t in_cmd;
  line_cmd_t head_cmd;
  line_cmd_t cur_q;
  q_state_t  state_q, state_d;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop;
  logic      timeout_hit;

  // Clear commands carry no geometry, so their endpoints are stored as zero.
  always_comb begin
    in_cmd       = '0;
    in_cmd.clear = cmd_clear;
    if (!cmd_clear) begin
      in_cmd.x0 = clamp_x(cmd_x0, MaxX);
      in_cmd.y0 = clamp_y(cmd_y0, MaxY);
      in_cmd.x1 = clamp_x(cmd_x1, MaxX);
      in_cmd.y1 = clamp_y(cmd_y1, MaxY);
    end
  end

  line_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (cmd_valid),
    .wdata(in_cmd),
    .pop  (pop),
    .rdata(head_cmd),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(queue_count)
  );

  assign cmd_ready = ~fifo_full;
  assign pop       = (state_q == IDLE) && !fifo_empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (draw_done || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) cur_q <= head_cmd;
    end
  end

  // Endpoints stay on the registered head until the next pop.
  assign draw_x0    = cur_q.x0;
  assign draw_y0    = cur_q.y0;
  assign draw_x1    = cur_q.x1;
  assign draw_y1    = cur_q.y1;
  assign draw_start = (state_q == ISSUE) && !cur_q.clear;
  assign draw_clean = (state_q == ISSUE) && cur_q.clear;
  assign busy       = (state_q != IDLE);

`ifdef LINE_CMD_QUEUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_err_q;

  // Fires on the TIMEOUT_CYCLES-th WAIT edge without draw_done.
  assign timeout_hit = (state_q == WAIT) && !draw_done &&
                       (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ISSUE) begin
      wait_cnt_d = '0;
    end else if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_q | timeout_hit;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_cmd_queue.sv
// Self-checking bench for line_cmd_queue: queue-based reference model plus directed vectors.
// Build with LINE_CMD_QUEUE_TIMEOUT_EN defined to also exercise the watchdog.
module tb_line_cmd_queue;
  import line_gfx_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 16;
`ifdef LINE_CMD_QUEUE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_clear = 1'b0;
  logic [9:0] cmd_x0 = '0;
  logic [8:0] cmd_y0 = '0;
  logic [9:0] cmd_x1 = '0;
  logic [8:0] cmd_y1 = '0;
  logic [9:0] draw_x0;
  logic [8:0] draw_y0;
  logic [9:0] draw_x1;
  logic [8:0] draw_y1;
  logic       draw_start;
  logic       draw_clean;
  logic       draw_done = 1'b0;
  logic       busy;
  logic [3:0] queue_count;
  logic       timeout_err;

  line_cmd_queue #(
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_clear  (cmd_clear),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_x1     (cmd_x1),
    .cmd_y1     (cmd_y1),
    .draw_x0    (draw_x0),
    .draw_y0    (draw_y0),
    .draw_x1    (draw_x1),
    .draw_y1    (draw_y1),
    .draw_start (draw_start),
    .draw_clean (draw_clean),
    .draw_done  (draw_done),
    .busy       (busy),
    .queue_count(queue_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of pending commands and the command the drawer is working on.
  line_cmd_t mq[$];
  line_cmd_t m_cur   = '0;
  int        m_phase = 0;  // 0 idle, 1 pulse cycle, 2 waiting for done
  int        m_wcnt  = 0;
  bit        m_terr  = 1'b0;
  bit        m_acc;

  function automatic line_cmd_t mk(input logic c, input logic [9:0] x0, input logic [8:0] y0,
                                   input logic [9:0] x1, input logic [8:0] y1);
    line_cmd_t r = '0;
    r.clear = c;
    if (!c) begin
      r.x0 = (x0 > 10'd639) ? 10'd639 : x0;
      r.y0 = (y0 > 9'd479) ? 9'd479 : y0;
      r.x1 = (x1 > 10'd639) ? 10'd639 : x1;
      r.y1 = (y1 > 9'd479) ? 9'd479 : y1;
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
        m_cur   = '0;
        m_phase = 0;
        m_wcnt  = 0;
        m_terr  = 1'b0;
      end else begin
        m_acc = cmd_valid && (mq.size() < DEPTH);
        if (m_phase == 0) begin
          if (mq.size() > 0) begin
            m_cur   = mq.pop_front();
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
          m_wcnt  = 0;
        end else if (draw_done) begin
          m_phase = 0;
        end else if (TO_EN) begin
          m_wcnt = m_wcnt + 1;
          if (m_wcnt == TO) begin
            m_phase = 0;
            m_terr  = 1'b1;
          end
        end
        if (m_acc) mq.push_back(mk(cmd_clear, cmd_x0, cmd_y0, cmd_x1, cmd_y1));
      end
    end
  end

  always @(negedge clk) begin
    check("queue_count", queue_count, mq.size());
    if (reset) check("cmd_ready", cmd_ready, mq.size() < DEPTH);
    check("draw_start", draw_start, (m_phase == 1) && !m_cur.clear);
    check("draw_clean", draw_clean, (m_phase == 1) && m_cur.clear);
    check("busy", busy, m_phase != 0);
    check("endpoints", {draw_x0, draw_y0, draw_x1, draw_y1},
          {m_cur.x0, m_cur.y0, m_cur.x1, m_cur.y1});
    check("timeout_err", timeout_err, m_terr);
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input bit c, input int x0, input int y0, input int x1, input int y1);
    bit r = 1'b0;
    cmd_clear = c;
    cmd_x0    = 10'(x0);
    cmd_y0    = 9'(y0);
    cmd_x1    = 10'(x1);
    cmd_y1    = 9'(y1);
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !r; i++) begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
    end
    #1 cmd_valid = 1'b0;
    check("push_accepted", r, 1);
  endtask

  // Returns at the falling edge inside the pulse cycle.
  task automatic wait_pulse();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = draw_start | draw_clean;
    end
    check("pulse_seen", seen, 1);
  endtask

  task automatic finish_cmd();
    @(posedge clk);
    #1 draw_done = 1'b1;
    @(posedge clk);
    #1 draw_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_count", queue_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);

    // Line (10,10)->(240,10): pulse in the cycle after the popping edge.
    push(0, 10, 10, 240, 10);
    @(negedge clk);
    check("lat_no_early_start", draw_start, 0);
    check("lat_count", queue_count, 1);
    @(negedge clk);
    check("lat_start", draw_start, 1);
    check("lat_x0", draw_x0, 10);
    check("lat_y0", draw_y0, 10);
    check("lat_x1", draw_x1, 240);
    check("lat_y1", draw_y1, 10);
    @(negedge clk);
    check("lat_start_one_cycle", draw_start, 0);
    check("lat_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1 draw_done = 1'b1;
    @(posedge clk);
    #1 draw_done = 1'b0;
    @(negedge clk);
    check("lat_busy_drop", busy, 0);

    // Clamp.
    @(posedge clk);
    #1;
    push(0, 700, 10, 5, 500);
    wait_pulse();
    check("clamp_x0", draw_x0, 639);
    check("clamp_y0", draw_y0, 10);
    check("clamp_x1", draw_x1, 5);
    check("clamp_y1", draw_y1, 479);
    finish_cmd();

    // Fill: one issued, eight queued, tenth held off.
    for (int i = 0; i < 9; i++) push(0, 20 + i, 30, 40 + i, 50);
    @(negedge clk);
    check("full_count", queue_count, 8);
    check("full_ready", cmd_ready, 0);
    cmd_x0    = 10'd999;
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("full_held_off", queue_count, 8);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) wait_pulse();
      check("order_x0", draw_x0, 20 + i);
      check("order_x1", draw_x1, 40 + i);
      finish_cmd();
    end
    @(negedge clk);
    check("drain_count", queue_count, 0);

    // Clear followed by a line.
    @(posedge clk);
    #1;
    push(1, 100, 100, 200, 200);
    push(0, 1, 2, 3, 4);
    wait_pulse();
    check("clr_clean", draw_clean, 1);
    check("clr_start", draw_start, 0);
    check("clr_x0_zero", draw_x0, 0);
    check("clr_x1_zero", draw_x1, 0);
    finish_cmd();
    wait_pulse();
    check("after_clr_start", draw_start, 1);
    check("after_clr_x0", draw_x0, 1);
    check("after_clr_y1", draw_y1, 4);
    finish_cmd();

    // Reset in WAIT with three entries queued.
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push(0, 300 + i, 7, 310 + i, 8);
    @(negedge clk);
    check("pre_rst_count", queue_count, 3);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_count", queue_count, 0);
    check("async_x0", draw_x0, 0);
    check("async_x1", draw_x1, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_start", draw_start, 0);
      check("post_rst_no_clean", draw_clean, 0);
    end
    @(posedge clk);
    #1;
    push(0, 55, 66, 77, 88);
    wait_pulse();
    check("post_rst_x0", draw_x0, 55);
    check("post_rst_y0", draw_y0, 66);
    finish_cmd();

`ifdef LINE_CMD_QUEUE_TIMEOUT_EN
    // Never answer done: watchdog must release WAIT after 16 edges.
    @(posedge clk);
    #1;
    push(0, 500, 1, 501, 2);
    push(0, 502, 3, 503, 4);
    wait_pulse();
    check("to_first_x0", draw_x0, 500);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n = n + 1;
      if (draw_start) break;
    end
    check("to_gap_cycles", n, 18);
    check("to_err", timeout_err, 1);
    check("to_second_x0", draw_x0, 502);
    repeat (25) @(negedge clk);
    check("to_err_sticky", timeout_err, 1);
`else
    // Without the watchdog a silent drawer keeps the queue waiting.
    @(posedge clk);
    #1;
    push(0, 600, 1, 601, 2);
    wait_pulse();
    n = 0;
    repeat (40) @(negedge clk);
    check("no_to_busy", busy, 1);
    check("no_to_err", timeout_err, 0);
    finish_cmd();
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
